// File: rtl/spike_count_decoder_if.sv
// spike_count_decoder_if: spike input, window strobe and class handshake bundle; sat_flag exists unless SPIKE_DECODER_SAT_EN is defined
interface spike_count_decoder_if #(
  parameter int N_OUT = 2,
  parameter int CNT_W = 5
);
  localparam int IDX_W = $clog2(N_OUT) > 1 ? $clog2(N_OUT) : 1;
  logic             spike_valid;
  logic [N_OUT-1:0] out_spikes;
  logic             window_done;
  logic [IDX_W-1:0] class_o;
  logic [CNT_W-1:0] class_count;
  logic             no_spike;
  logic             class_valid;
  logic             class_ready;
  logic             busy;
  logic             overrun;
`ifndef SPIKE_DECODER_SAT_EN
  logic             sat_flag;
`endif
  modport master (
    output spike_valid, out_spikes, window_done, class_ready,
    input  class_o, class_count, no_spike, class_valid, busy, overrun
`ifndef SPIKE_DECODER_SAT_EN
    , sat_flag
`endif
  );
  modport slave (
    input  spike_valid, out_spikes, window_done, class_ready,
    output class_o, class_count, no_spike, class_valid, busy, overrun
`ifndef SPIKE_DECODER_SAT_EN
    , sat_flag
`endif
  );
endinterface

// File: rtl/spike_count_decoder.sv
// spike_count_decoder: per-neuron spike counts, sequential argmax, class handshake
// Define SPIKE_DECODER_SAT_EN for saturating counters; otherwise counters wrap and sat_flag is sticky.
module spike_count_decoder #(
  parameter int N_OUT = 2,
  parameter int CNT_W = 5
) (
  input logic             clk,
  input logic             rst,
  spike_count_decoder_if.slave bus
);
  localparam int IDX_W = $clog2(N_OUT) > 1 ? $clog2(N_OUT) : 1;
  localparam int SW    = $clog2(N_OUT + 1);
  typedef enum logic [1:0] {ACCUM, SCAN, HOLD} state_t;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt [N_OUT];
  logic [CNT_W-1:0] nxt [N_OUT];
  logic [CNT_W-1:0] snap [N_OUT];
  logic [CNT_W-1:0] cur, best;
  logic [SW-1:0]    idx;
  logic [IDX_W-1:0] best_idx;
  logic             scan_end;
`ifndef SPIKE_DECODER_SAT_EN
  logic [N_OUT-1:0] wrap;
`endif
  always_comb begin
    cur = '0;
`ifndef SPIKE_DECODER_SAT_EN
    wrap = '0;
`endif
    for (int i = 0; i < N_OUT; i++) begin
      if (idx == SW'(i)) cur = snap[i];
`ifdef SPIKE_DECODER_SAT_EN
      nxt[i] = (bus.spike_valid && bus.out_spikes[i] && cnt[i] != '1) ? cnt[i] + 1'b1 : cnt[i];
`else
      {wrap[i], nxt[i]} = {1'b0, cnt[i]} + (CNT_W + 1)'(bus.spike_valid & bus.out_spikes[i]);
`endif
    end
  end
  // idx runs one past the last neuron so the result registers one cycle after the final compare
  assign scan_end = state == SCAN && idx == SW'(N_OUT);
  always_comb
    state_n = (state == ACCUM && bus.window_done) ? SCAN :
              scan_end                            ? HOLD :
              (state == HOLD && bus.class_ready)  ? ACCUM : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < N_OUT; i++) begin
        cnt[i]  <= '0;
        snap[i] <= '0;
      end
      state           <= ACCUM;
      idx             <= '0;
      best            <= '0;
      best_idx        <= '0;
      bus.class_o     <= '0;
      bus.class_count <= '0;
      bus.no_spike    <= 1'b0;
      bus.class_valid <= 1'b0;
      bus.busy        <= 1'b0;
      bus.overrun     <= 1'b0;
`ifndef SPIKE_DECODER_SAT_EN
      bus.sat_flag    <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        cnt[i] <= bus.window_done ? '0 : nxt[i];
        if (state == ACCUM && bus.window_done) snap[i] <= nxt[i];
      end
`ifndef SPIKE_DECODER_SAT_EN
      bus.sat_flag <= bus.sat_flag | (|wrap);
`endif
      state           <= state_n;
      bus.busy        <= state_n == SCAN;
      bus.class_valid <= state_n == HOLD;
      if (state != ACCUM && bus.window_done) bus.overrun <= 1'b1;
      idx <= state == SCAN ? idx + 1'b1 : '0;
      if (state == ACCUM) begin
        best     <= '0;
        best_idx <= '0;
      end else if (state == SCAN && cur > best) begin
        best     <= cur;
        best_idx <= idx[IDX_W-1:0];
      end
      if (scan_end) begin
        bus.class_o     <= best_idx;
        bus.class_count <= best;
        bus.no_spike    <= best == '0;
      end
    end
endmodule
